gray2rgb_colormap: RTL and testbench



---
 rtl/gray2rgb_pkg.sv | 23 ++
 rtl/gray2rgb_palette.sv | 31 +++
 rtl/gray2rgb_colormap.sv | 152 +++++++++++++++
 tb/tb_gray2rgb_colormap.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gray2rgb_pkg.sv
// gray2rgb_pkg: shared sizes, RGB struct and reset-ramp helper for the grey-to-RGB colormap
package gray2rgb_pkg;

    localparam int PAL_DEPTH = 16;
    localparam int IDX_W     = 4;
    localparam int FRAC_W    = 6;
    localparam int CH_W      = 10;
    localparam int DIFF_W    = CH_W + 1;
    localparam int PROD_W    = DIFF_W + FRAC_W;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb10_t;

    function automatic rgb10_t ramp_entry(input logic [IDX_W-1:0] k);
        logic [CH_W-1:0] v;
        v = CH_W'(k) * CH_W'(68);
        return '{r: v, g: v, b: v};
    endfunction

endpackage

// File: rtl/gray2rgb_palette.sv
// gray2rgb_palette: 16-entry RGB palette, one write port, reads at idx and clamped idx+1
module gray2rgb_palette
    import gray2rgb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  rgb10_t           wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output rgb10_t           rd0_o,
    output rgb10_t           rd1_o
);

    rgb10_t           mem_q [PAL_DEPTH];
    logic [IDX_W-1:0] raddr_nxt;

    // Palette flops: reset restores the grey ramp, otherwise one write per clock
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < PAL_DEPTH; k++) mem_q[k] <= ramp_entry(IDX_W'(k));
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign raddr_nxt = (raddr_i == IDX_W'(PAL_DEPTH - 1)) ? raddr_i : raddr_i + IDX_W'(1);
    assign rd0_o     = mem_q[raddr_i];
    assign rd1_o     = mem_q[raddr_nxt];

endmodule

// File: rtl/gray2rgb_colormap.sv
// gray2rgb_colormap: 3-stage grey-to-RGB expander; GRAY2RGB_INTERP_EN selects interpolating palette lookup
module gray2rgb_colormap
    import gray2rgb_pkg::*;
(
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic [CH_W-1:0]     iGray,
    input  logic                iValid,
    input  logic                iMode,
    input  logic                iPalWe,
    input  logic [IDX_W-1:0]    iPalAddr,
    input  logic [3*CH_W-1:0]   iPalData,
    output logic [CH_W-1:0]     oRed,
    output logic [CH_W-1:0]     oGreen,
    output logic [CH_W-1:0]     oBlue,
    output logic                oValid
);

    rgb10_t          pal_lo, pal_hi;
    logic            s1_valid_q, s1_mode_q;
    logic [CH_W-1:0] s1_gray_q;
    rgb10_t          s1_lo_q;
    logic            s2_valid_q;
    rgb10_t          s2_base_d, s2_base_q;
    rgb10_t          mapped, out_d, out_q;
    logic            out_valid_q;

    gray2rgb_palette u_palette (
        .clk_i   (iCLK),
        .rst_ni  (iRST_n),
        .we_i    (iPalWe),
        .waddr_i (iPalAddr),
        .wdata_i (rgb10_t'(iPalData)),
        .raddr_i (iGray[CH_W-1:FRAC_W]),
        .rd0_o   (pal_lo),
        .rd1_o   (pal_hi)
    );

`ifdef GRAY2RGB_INTERP_EN
    logic [FRAC_W-1:0]        s1_frac_q;
    rgb10_t                   s1_hi_q;
    logic signed [PROD_W-1:0] s2_prod_d [3];
    logic signed [PROD_W-1:0] s2_prod_q [3];

    // Signed (hi - lo) * frac; mode 0 contributes no product so the base passes through
    function automatic logic signed [PROD_W-1:0] lerp_prod(input logic [CH_W-1:0] lo, hi,
                                                           input logic [FRAC_W-1:0] frac);
        logic signed [DIFF_W-1:0] diff;
        logic signed [PROD_W:0]   full;
        diff = $signed({1'b0, hi}) - $signed({1'b0, lo});
        full = diff * $signed({1'b0, frac});
        return PROD_W'(full);
    endfunction

    // Arithmetic shift floors toward -inf, keeping the result between the two entries
    function automatic logic [CH_W-1:0] lerp_add(input logic [CH_W-1:0] base,
                                                 input logic signed [PROD_W-1:0] prod);
        logic signed [PROD_W-1:0] sum;
        sum = $signed({{(PROD_W - CH_W){1'b0}}, base}) + (prod >>> FRAC_W);
        return CH_W'(sum);
    endfunction

    // Interpolation extras for stage 1: fraction and the upper palette entry
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            s1_frac_q <= '0;
            s1_hi_q   <= '0;
        end else begin
            s1_frac_q <= iGray[FRAC_W-1:0];
            s1_hi_q   <= pal_hi;
        end
    end

    // Stage 2 products per channel, zero in replicate mode
    always_comb begin
        s2_prod_d[0] = s1_mode_q ? lerp_prod(s1_lo_q.r, s1_hi_q.r, s1_frac_q) : '0;
        s2_prod_d[1] = s1_mode_q ? lerp_prod(s1_lo_q.g, s1_hi_q.g, s1_frac_q) : '0;
        s2_prod_d[2] = s1_mode_q ? lerp_prod(s1_lo_q.b, s1_hi_q.b, s1_frac_q) : '0;
    end

    // Stage 2 product registers
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int c = 0; c < 3; c++) s2_prod_q[c] <= '0;
        end else begin
            for (int c = 0; c < 3; c++) s2_prod_q[c] <= s2_prod_d[c];
        end
    end

    assign mapped = '{r: lerp_add(s2_base_q.r, s2_prod_q[0]),
                      g: lerp_add(s2_base_q.g, s2_prod_q[1]),
                      b: lerp_add(s2_base_q.b, s2_prod_q[2])};
`else
    logic unused_nearest;

    assign unused_nearest = ^{pal_hi, iGray[FRAC_W-1:0]};
    assign mapped         = s2_base_q;
`endif

    // Stage 1: capture the pixel, its mode and the lower palette entry
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_gray_q  <= '0;
            s1_lo_q    <= '0;
        end else begin
            s1_valid_q <= iValid;
            s1_mode_q  <= iMode;
            s1_gray_q  <= iGray;
            s1_lo_q    <= pal_lo;
        end
    end

    // Base colour: palette entry in map mode, replicated grey otherwise
    always_comb begin
        s2_base_d = s1_mode_q ? s1_lo_q : '{r: s1_gray_q, g: s1_gray_q, b: s1_gray_q};
    end

    // Stage 2 base and valid registers
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            s2_valid_q <= 1'b0;
            s2_base_q  <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_base_q  <= s2_base_d;
        end
    end

    // Outputs only move on a valid pixel so gaps hold the last colour
    always_comb begin
        out_d = s2_valid_q ? mapped : out_q;
    end

    // Stage 3 output registers
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= s2_valid_q;
            out_q       <= out_d;
        end
    end

    assign oRed   = out_q.r;
    assign oGreen = out_q.g;
    assign oBlue  = out_q.b;
    assign oValid = out_valid_q;

endmodule

// File: tb/tb_gray2rgb_colormap.sv
// tb_gray2rgb_colormap: directed and streamed checks of the grey-to-RGB colormap
module tb_gray2rgb_colormap;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic [9:0]  iGray = '0;
    logic        iValid = 1'b0;
    logic        iMode = 1'b0;
    logic        iPalWe = 1'b0;
    logic [3:0]  iPalAddr = '0;
    logic [29:0] iPalData = '0;
    logic [9:0]  oRed, oGreen, oBlue;
    logic        oValid;

    int          tests = 0;
    int          fails = 0;
    logic [29:0] pal_m [16];
    logic        qv [$];
    logic [29:0] qc [$];
    logic [29:0] last_exp;

`ifdef GRAY2RGB_INTERP_EN
    localparam logic [29:0] E100 = {10'd106, 10'd106, 10'd106};
    localparam logic [29:0] E160 = {10'd511, 10'd0, 10'd511};
`else
    localparam logic [29:0] E100 = {10'd68, 10'd68, 10'd68};
    localparam logic [29:0] E160 = {10'd1023, 10'd0, 10'd0};
`endif
    localparam logic [29:0] E1020 = {10'd1020, 10'd1020, 10'd1020};

    gray2rgb_colormap dut (
        .iCLK     (iCLK),
        .iRST_n   (iRST_n),
        .iGray    (iGray),
        .iValid   (iValid),
        .iMode    (iMode),
        .iPalWe   (iPalWe),
        .iPalAddr (iPalAddr),
        .iPalData (iPalData),
        .oRed     (oRed),
        .oGreen   (oGreen),
        .oBlue    (oBlue),
        .oValid   (oValid)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] model(input logic [9:0] g, input logic m);
        logic [3:0]  idx;
        logic [29:0] lo, res;
        int          a, v;
`ifdef GRAY2RGB_INTERP_EN
        logic [29:0] hi;
        int          b, f;
`endif
        if (!m) return {g, g, g};
        idx = g[9:6];
        lo  = pal_m[idx];
`ifdef GRAY2RGB_INTERP_EN
        hi = pal_m[idx == 4'd15 ? idx : idx + 4'd1];
        f  = int'(g[5:0]);
`endif
        res = '0;
        for (int c = 0; c < 3; c++) begin
            a = int'(lo[c*10 +: 10]);
`ifdef GRAY2RGB_INTERP_EN
            b = int'(hi[c*10 +: 10]);
            v = a + (((b - a) * f) >>> 6);
`else
            v = a;
`endif
            res[c*10 +: 10] = 10'(v);
        end
        return res;
    endfunction

    task automatic ramp_model();
        for (int k = 0; k < 16; k++) pal_m[k] = {3{10'(68 * k)}};
    endtask

    task automatic drive(input logic v, input logic [9:0] g, input logic m,
                         input logic we, input logic [3:0] addr, input logic [29:0] data);
        iValid   = v;
        iGray    = g;
        iMode    = m;
        iPalWe   = we;
        iPalAddr = addr;
        iPalData = data;
        @(posedge iCLK);
        #1;
        if (we) pal_m[addr] = data;
        iValid = 1'b0;
        iPalWe = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 10'd0, 1'b0, 1'b0, 4'd0, 30'd0);
    endtask

    task automatic sstep(input logic v, input logic [9:0] g, input logic m);
        logic [29:0] e;
        logic        pv;
        logic [29:0] pc;
        e = model(g, m);
        drive(v, g, m, 1'b0, 4'd0, 30'd0);
        qv.push_back(v);
        qc.push_back(e);
        if (qv.size() == 3) begin
            pv = qv.pop_front();
            pc = qc.pop_front();
            chk("stream_valid", {31'd0, oValid}, {31'd0, pv});
            if (pv) last_exp = pc;
            chk("stream_rgb", {2'd0, oRed, oGreen, oBlue}, {2'd0, last_exp});
        end
    endtask

    initial begin
        ramp_model();
        #1;
        chk("reset_valid", {31'd0, oValid}, 32'd0);
        chk("reset_rgb", {2'd0, oRed, oGreen, oBlue}, 32'd0);
        repeat (2) @(posedge iCLK);
        #1;
        iRST_n = 1'b1;

        drive(1'b1, 10'd512, 1'b0, 1'b0, 4'd0, 30'd0);
        idle();
        chk("m0_early_valid", {31'd0, oValid}, 32'd0);
        idle();
        chk("m0_valid", {31'd0, oValid}, 32'd1);
        chk("m0_rgb", {2'd0, oRed, oGreen, oBlue}, {2'd0, 10'd512, 10'd512, 10'd512});
        idle();
        chk("m0_gap_valid", {31'd0, oValid}, 32'd0);
        chk("m0_hold_rgb", {2'd0, oRed, oGreen, oBlue}, {2'd0, 10'd512, 10'd512, 10'd512});

        drive(1'b1, 10'd1023, 1'b1, 1'b0, 4'd0, 30'd0);
        idle();
        idle();
        chk("clamp15_rgb", {2'd0, oRed, oGreen, oBlue}, {2'd0, E1020});

        drive(1'b1, 10'd100, 1'b1, 1'b0, 4'd0, 30'd0);
        idle();
        idle();
        chk("g100_rgb", {2'd0, oRed, oGreen, oBlue}, {2'd0, E100});

        drive(1'b0, 10'd0, 1'b0, 1'b1, 4'd2, {10'd1023, 10'd0, 10'd0});
        drive(1'b0, 10'd0, 1'b0, 1'b1, 4'd3, {10'd0, 10'd0, 10'd1023});
        drive(1'b1, 10'd160, 1'b1, 1'b0, 4'd0, 30'd0);
        idle();
        idle();
        chk("g160_rgb", {2'd0, oRed, oGreen, oBlue}, {2'd0, E160});

        drive(1'b1, 10'd320, 1'b1, 1'b1, 4'd5, 30'd0);
        drive(1'b1, 10'd320, 1'b1, 1'b0, 4'd0, 30'd0);
        idle();
        chk("wr_same_edge_valid", {31'd0, oValid}, 32'd1);
        chk("wr_same_edge_rgb", {2'd0, oRed, oGreen, oBlue}, {2'd0, 10'd340, 10'd340, 10'd340});
        idle();
        chk("wr_next_valid", {31'd0, oValid}, 32'd1);
        chk("wr_next_rgb", {2'd0, oRed, oGreen, oBlue}, 32'd0);
        idle();
        chk("wr_tail_valid", {31'd0, oValid}, 32'd0);

        qv.delete();
        qc.delete();
        last_exp = '0;
        for (int g = 0; g < 1024; g++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) sstep(1'b0, 10'($urandom), 1'($urandom));
            if (g == 600) begin
                #3;
                iRST_n = 1'b0;
                #1;
                chk("rst_async_valid", {31'd0, oValid}, 32'd0);
                chk("rst_async_rgb", {2'd0, oRed, oGreen, oBlue}, 32'd0);
                @(posedge iCLK);
                #1;
                iRST_n = 1'b1;
                ramp_model();
                qv.delete();
                qc.delete();
                repeat (3) begin
                    idle();
                    chk("rst_no_stale", {31'd0, oValid}, 32'd0);
                end
                drive(1'b1, 10'd1023, 1'b1, 1'b0, 4'd0, 30'd0);
                idle();
                idle();
                chk("rst_ramp_valid", {31'd0, oValid}, 32'd1);
                chk("rst_ramp_rgb", {2'd0, oRed, oGreen, oBlue}, {2'd0, E1020});
                last_exp = E1020;
            end
            sstep(1'b1, 10'(g), 1'($urandom));
        end
        repeat (3) sstep(1'b0, 10'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
